painterengine_gpu_fill_writer: RTL and testbench
================================================

# painterengine_gpu_fill_writer

Rectangle-fill pixel generator on the GPU write-clock domain; sits directly upstream of the GPU FIFO and drives its write port. Once started, it emits `width*height` pixel words in row-major order, either a solid colour or a two-colour checker pattern. It stalls on FIFO full and never drops or duplicates a pixel. It reports busy, done and the number of pixels pushed.

## Interface
Parameters:
- PARAM_DATA_WIDTH, 32, pixel word width; equals the FIFO data width.
- PARAM_COORD_WIDTH, 12, width of the x/y and size fields.
- PARAM_CHECKER_SHIFT, 3, log2 of checker cell edge in pixels.

Ports:
- Clock and reset: i_wire_resetn is asynchronous, active-low; the clock is i_wire_write_clock.
- i_wire_write_clock  in  1  block clock; same clock as the FIFO write side.
- i_wire_resetn  in  1  async active-low reset.
- i_wire_start  in  1  start request; sampled in IDLE only.
- i_wire_abort  in  1  abort the current fill.
- i_wire_mode  in  1  0 = solid color0, 1 = checker.
- i_wire_width  in  PARAM_COORD_WIDTH  rectangle width in pixels.
- i_wire_height  in  PARAM_COORD_WIDTH  rectangle height in pixels.
- i_wire_color0  in  PARAM_DATA_WIDTH  solid / even-cell colour.
- i_wire_color1  in  PARAM_DATA_WIDTH  odd-cell colour.
- i_wire_fifo_full  in  1  FIFO full flag.
- o_wire_fifo_write  out  1  FIFO write strobe.
- o_wire_fifo_data  out  PARAM_DATA_WIDTH  FIFO write data.
- o_wire_busy  out  1  high in RUN and DONE.
- o_wire_done  out  1  one-cycle completion pulse.
- o_wire_pixel_count  out  2*PARAM_COORD_WIDTH  pixels accepted by the FIFO in the current or last fill.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch mode, width, height, color0 and color1 into shadow registers.
  - Clear x, y and pixel_count.
  - Go to RUN. If width==0 or height==0, go to DONE instead.
- RUN:
  - o_wire_fifo_write = !i_wire_fifo_full. This is combinational from the registered state and the flag, so the write is accepted at the same edge.
  - Each accepted write:
    - Increments x and pixel_count.
    - When x==width-1: x becomes 0 and y increments.
    - When x==width-1 and y==height-1: go to DONE.
- DONE: assert o_wire_done for exactly one cycle, then go to IDLE.
- Pixel data:
  - mode 0: color0.
  - mode 1: ((x>>PARAM_CHECKER_SHIFT) ^ (y>>PARAM_CHECKER_SHIFT)) bit0 ? color1 : color0.
  - Uses the shadowed values only; input changes during RUN have no effect.
- o_wire_fifo_data is valid and stable whenever o_wire_fifo_write=1. It holds its last value otherwise.
- Abort:
  - In RUN or DONE, abort=1 goes to IDLE at the next edge.
  - No done pulse; pixel_count holds.
  - No write is issued in the abort cycle.
  - Abort has priority over start.
- start while busy: ignored.
- Arithmetic: x and y are unsigned PARAM_COORD_WIDTH wide. pixel_count is 2*PARAM_COORD_WIDTH wide and cannot overflow (max (2^C-1)^2).
- Reset (async, at any time, including mid-fill):
  - State IDLE.
  - x, y, pixel_count, data, and all outputs return to 0.
  - Shadow registers are cleared.

## Timing
- start sampled at edge k → RUN from k; first write strobe in cycle k..k+1; first pixel accepted at edge k+1 if not full.
- With no back-pressure: one pixel per cycle, N=w*h pixels accepted at edges k+1..k+N.
- DONE is entered at edge k+N, o_wire_done is high in cycle k+N..k+N+1, and state is IDLE at k+N+1.
- Zero-size fill: done pulse in the cycle after start; no writes.
- Full: i_wire_fifo_full=1 → o_wire_fifo_write=0 in the same cycle; counters hold; data holds.
- The FIFO full flag only falls asynchronously from the read side. A single writer therefore never overruns.
- Next start is accepted in the cycle after DONE (state IDLE).

## Structure
- Shared package painterengine_gpu_pkg holds:
  - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Mode constants MODE_SOLID=1'b0, MODE_CHECKER=1'b1.
- One sub-module: painterengine_gpu_raster_counter (x/y counter with enable, clear, width/height bounds, last flag). It is reusable by future blit/copy stages.

## Test plan
- Solid 4x2, color0=32'hFF00FF00, full=0 → 8 consecutive writes of FF00FF00, done at cycle 9 after start, pixel_count=8.
- Checker 16x16, shift=3, color0=0, color1=1 → pixel (8,0)=1, (8,8)=0, (0,8)=1; 256 writes total.
- 4x1 with full held high for cycles 2–5 → no strobe while full; 4 distinct writes in order x=0..3; no duplicates.
- width=0, height=5, start → no writes, done pulse the next cycle, pixel_count=0.
- 8x8 with abort after 10 pixels → state IDLE next edge, no done, pixel_count=10; new start then runs a full 64-pixel fill.
- Reset asserted mid-fill → all outputs 0 immediately; after release, start works normally.

Source files
------------

// File: rtl/painterengine_gpu_pkg.sv
// ---------------------------------------------------------------------------
// painterengine_gpu_pkg
// Shared definitions for the PainterEngine GPU write-side blocks.
//   state_e      : fill-writer FSM encoding (IDLE / RUN / DONE)
//   MODE_SOLID   : fill every pixel with color0
//   MODE_CHECKER : alternate color0 / color1 per checker cell
// ---------------------------------------------------------------------------
package painterengine_gpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic MODE_SOLID   = 1'b0;
   localparam logic MODE_CHECKER = 1'b1;

endpackage : painterengine_gpu_pkg

// File: rtl/painterengine_gpu_raster_counter.sv
// ---------------------------------------------------------------------------
// painterengine_gpu_raster_counter
// Row-major x/y walker over a width x height rectangle.
// Ports:
//   i_wire_clock / i_wire_resetn : clock, async active-low reset
//   i_wire_clear                 : zero x and y (wins over enable)
//   i_wire_enable                : advance one pixel
//   i_wire_width / i_wire_height : rectangle bounds (must be non-zero while
//                                  enabled)
//   o_wire_x / o_wire_y          : current pixel coordinate
//   o_wire_last                  : current pixel is the final one
// ---------------------------------------------------------------------------
module painterengine_gpu_raster_counter #(
   parameter int PARAM_COORD_WIDTH = 12
) (
   input  logic                         i_wire_clock,
   input  logic                         i_wire_resetn,
   input  logic                         i_wire_clear,
   input  logic                         i_wire_enable,
   input  logic [PARAM_COORD_WIDTH-1:0] i_wire_width,
   input  logic [PARAM_COORD_WIDTH-1:0] i_wire_height,
   output logic [PARAM_COORD_WIDTH-1:0] o_wire_x,
   output logic [PARAM_COORD_WIDTH-1:0] o_wire_y,
   output logic                         o_wire_last
);

   localparam int CW = PARAM_COORD_WIDTH;
   localparam logic [CW-1:0] COORD_ONE = CW'(1);

   logic [CW-1:0] x_q, x_d;
   logic [CW-1:0] y_q, y_d;
   logic          row_end;

   assign row_end     = (x_q == (i_wire_width - COORD_ONE));
   assign o_wire_last = row_end && (y_q == (i_wire_height - COORD_ONE));
   assign o_wire_x    = x_q;
   assign o_wire_y    = y_q;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (i_wire_clear) begin
         x_d = '0;
         y_d = '0;
      end else if (i_wire_enable) begin
         if (row_end) begin
            x_d = '0;
            y_d = y_q + COORD_ONE;
         end else begin
            x_d = x_q + COORD_ONE;
         end
      end
   end

   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

endmodule : painterengine_gpu_raster_counter

// File: rtl/painterengine_gpu_fill_writer.sv
// ---------------------------------------------------------------------------
// painterengine_gpu_fill_writer
// Rectangle-fill pixel generator driving the GPU FIFO write port. Emits
// width*height pixels in row-major order, solid color0 or a two-colour
// checker, stalling on FIFO full without dropping or repeating pixels.
// Ports:
//   i_wire_write_clock / i_wire_resetn : clock, async active-low reset
//   i_wire_start / i_wire_abort        : begin fill (IDLE only) / cancel fill
//   i_wire_mode                        : MODE_SOLID or MODE_CHECKER
//   i_wire_width / i_wire_height       : rectangle size in pixels
//   i_wire_color0 / i_wire_color1      : even-cell (solid) / odd-cell colour
//   i_wire_fifo_full                   : FIFO back-pressure
//   o_wire_fifo_write / o_wire_fifo_data : FIFO write port
//   o_wire_busy / o_wire_done          : in RUN or DONE / completion pulse
//   o_wire_pixel_count                 : pixels accepted in current/last fill
// Handshake: a pixel is transferred on every rising edge where
// o_wire_fifo_write is high; write is only raised when the FIFO is not full,
// so write==1 means the FIFO accepts the word at that same edge.
// ---------------------------------------------------------------------------
module painterengine_gpu_fill_writer
   import painterengine_gpu_pkg::*;
#(
   parameter int PARAM_DATA_WIDTH    = 32,
   parameter int PARAM_COORD_WIDTH   = 12,
   parameter int PARAM_CHECKER_SHIFT = 3
) (
   input  logic                           i_wire_write_clock,
   input  logic                           i_wire_resetn,
   input  logic                           i_wire_start,
   input  logic                           i_wire_abort,
   input  logic                           i_wire_mode,
   input  logic [PARAM_COORD_WIDTH-1:0]   i_wire_width,
   input  logic [PARAM_COORD_WIDTH-1:0]   i_wire_height,
   input  logic [PARAM_DATA_WIDTH-1:0]    i_wire_color0,
   input  logic [PARAM_DATA_WIDTH-1:0]    i_wire_color1,
   input  logic                           i_wire_fifo_full,
   output logic                           o_wire_fifo_write,
   output logic [PARAM_DATA_WIDTH-1:0]    o_wire_fifo_data,
   output logic                           o_wire_busy,
   output logic                           o_wire_done,
   output logic [2*PARAM_COORD_WIDTH-1:0] o_wire_pixel_count
);

   localparam int DW   = PARAM_DATA_WIDTH;
   localparam int CW   = PARAM_COORD_WIDTH;
   localparam int CNTW = 2 * PARAM_COORD_WIDTH;
   localparam logic [CNTW-1:0] COUNT_ONE = CNTW'(1);

   state_e          state_q, state_d;
   logic            mode_q, mode_d;
   logic [CW-1:0]   width_q, width_d;
   logic [CW-1:0]   height_q, height_d;
   logic [DW-1:0]   color0_q, color0_d;
   logic [DW-1:0]   color1_q, color1_d;
   logic [CNTW-1:0] count_q, count_d;
   logic [DW-1:0]   data_q, data_d;

   logic [CW-1:0]   x;
   logic [CW-1:0]   y;
   logic            last;
   logic            start_fire;
   logic            fifo_write;
   logic            checker_odd;
   logic [DW-1:0]   pixel;

   // Abort also blocks a start presented in the same cycle.
   assign start_fire = (state_q == ST_IDLE) && i_wire_start && !i_wire_abort;
   assign fifo_write = (state_q == ST_RUN) && !i_wire_abort && !i_wire_fifo_full;

   // Bit 0 of (coord >> shift) is simply bit 'shift' of the coordinate.
   assign checker_odd = x[PARAM_CHECKER_SHIFT] ^ y[PARAM_CHECKER_SHIFT];
   assign pixel = ((mode_q == MODE_CHECKER) && checker_odd) ? color1_q : color0_q;

   painterengine_gpu_raster_counter #(
      .PARAM_COORD_WIDTH (CW)
   ) u_raster_counter (
      .i_wire_clock  (i_wire_write_clock),
      .i_wire_resetn (i_wire_resetn),
      .i_wire_clear  (start_fire),
      .i_wire_enable (fifo_write),
      .i_wire_width  (width_q),
      .i_wire_height (height_q),
      .o_wire_x      (x),
      .o_wire_y      (y),
      .o_wire_last   (last)
   );

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      width_d  = width_q;
      height_d = height_q;
      color0_d = color0_q;
      color1_d = color1_q;
      count_d  = count_q;
      data_d   = data_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_fire) begin
               mode_d   = i_wire_mode;
               width_d  = i_wire_width;
               height_d = i_wire_height;
               color0_d = i_wire_color0;
               color1_d = i_wire_color1;
               count_d  = '0;
               if ((i_wire_width == '0) || (i_wire_height == '0)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (i_wire_abort) begin
               state_d = ST_IDLE;
            end else if (fifo_write) begin
               count_d = count_q + COUNT_ONE;
               data_d  = pixel;
               if (last) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_wire_write_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         state_q  <= ST_IDLE;
         mode_q   <= MODE_SOLID;
         width_q  <= '0;
         height_q <= '0;
         color0_q <= '0;
         color1_q <= '0;
         count_q  <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         width_q  <= width_d;
         height_q <= height_d;
         color0_q <= color0_d;
         color1_q <= color1_d;
         count_q  <= count_d;
         data_q   <= data_d;
      end
   end

   // Data follows the live pixel while writing and otherwise holds the last
   // word pushed, so it never glitches while the strobe is low.
   assign o_wire_fifo_write  = fifo_write;
   assign o_wire_fifo_data   = fifo_write ? pixel : data_q;
   assign o_wire_busy        = (state_q != ST_IDLE);
   assign o_wire_done        = (state_q == ST_DONE) && !i_wire_abort;
   assign o_wire_pixel_count = count_q;

endmodule : painterengine_gpu_fill_writer

// File: tb/tb_painterengine_gpu_fill_writer.sv
// ---------------------------------------------------------------------------
// tb_painterengine_gpu_fill_writer
// Bench for the rectangle-fill writer: expected pixel words are queued when
// a fill is started and popped as the DUT writes them.
// ---------------------------------------------------------------------------
module tb_painterengine_gpu_fill_writer;

   localparam int DW = 32;
   localparam int CW = 12;

   logic            clk = 1'b0;
   logic            resetn;
   logic            start;
   logic            abort;
   logic            mode;
   logic [CW-1:0]   width;
   logic [CW-1:0]   height;
   logic [DW-1:0]   color0;
   logic [DW-1:0]   color1;
   logic            full;
   logic            fifo_write;
   logic [DW-1:0]   fifo_data;
   logic            busy;
   logic            done;
   logic [2*CW-1:0] pixel_count;

   int              total = 0;
   int              bad = 0;
   int              wr_idx = 0;
   logic [DW-1:0]   exp_q[$];
   logic [DW-1:0]   cap[0:255];
   logic [DW-1:0]   last_data;
   logic [DW-1:0]   e_val;

   painterengine_gpu_fill_writer #(
      .PARAM_DATA_WIDTH    (DW),
      .PARAM_COORD_WIDTH   (CW),
      .PARAM_CHECKER_SHIFT (3)
   ) dut (
      .i_wire_write_clock (clk),
      .i_wire_resetn      (resetn),
      .i_wire_start       (start),
      .i_wire_abort       (abort),
      .i_wire_mode        (mode),
      .i_wire_width       (width),
      .i_wire_height      (height),
      .i_wire_color0      (color0),
      .i_wire_color1      (color1),
      .i_wire_fifo_full   (full),
      .o_wire_fifo_write  (fifo_write),
      .o_wire_fifo_data   (fifo_data),
      .o_wire_busy        (busy),
      .o_wire_done        (done),
      .o_wire_pixel_count (pixel_count)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [DW-1:0] model_pix(input logic m, input int x, input int y,
                                               input logic [DW-1:0] a, input logic [DW-1:0] b);
      if (m && ((((x >> 3) ^ (y >> 3)) & 1) == 1)) return b;
      return a;
   endfunction

   // ---------------- scoreboard monitor (samples mid-cycle) ----------------
   always @(negedge clk) begin
      if (!resetn) begin
         last_data = '0;
      end else if (fifo_write === 1'b1) begin
         total++;
         if (full) begin
            bad++;
            $display("FAIL wr_while_full: write=1 with full=1 at %0t", $time);
         end else if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: data=%h with empty queue at %0t", fifo_data, $time);
         end else begin
            e_val = exp_q.pop_front();
            if (fifo_data !== e_val) begin
               bad++;
               $display("FAIL pixel_data[%0d]: got %h expected %h", wr_idx, fifo_data, e_val);
            end
         end
         if (wr_idx < 256) cap[wr_idx] = fifo_data;
         wr_idx++;
         last_data = fifo_data;
      end else begin
         total++;
         if (fifo_data !== last_data) begin
            bad++;
            $display("FAIL data_hold: got %h expected %h at %0t", fifo_data, last_data, $time);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Presents a start for one edge and queues every expected pixel; afterwards
   // scrambles the inputs so any use of unshadowed values shows up.
   task automatic start_fill(input logic m, input int w, input int h,
                             input logic [DW-1:0] a, input logic [DW-1:0] b);
      @(posedge clk); #1;
      mode   = m;
      width  = CW'(w);
      height = CW'(h);
      color0 = a;
      color1 = b;
      start  = 1'b1;
      for (int yy = 0; yy < h; yy++)
         for (int xx = 0; xx < w; xx++)
            exp_q.push_back(model_pix(m, xx, yy, a, b));
      wr_idx = 0;
      @(posedge clk); #1;
      start  = 1'b0;
      mode   = ~m;
      width  = CW'($urandom_range(0, 20));
      height = CW'($urandom_range(0, 20));
      color0 = $urandom;
      color1 = $urandom;
   endtask

   // Steps cycles after the start edge until done is seen; cycle c is the
   // c-th mid-cycle sample after the start edge.
   task automatic run_and_wait(input int budget, input int full_lo, input int full_hi,
                               input bit rand_full, input int start_cyc, output int done_cyc);
      done_cyc = 0;
      for (int c = 1; c <= budget; c++) begin
         if (c > 1) begin @(posedge clk); #1; end
         full  = rand_full ? ($urandom_range(0, 3) == 0) : (c >= full_lo && c <= full_hi);
         start = (c == start_cyc);
         @(negedge clk);
         if (done === 1'b1) begin
            done_cyc = c;
            break;
         end
      end
      #1;
      full  = 1'b0;
      start = 1'b0;
      total++;
      if (done_cyc == 0) begin
         bad++;
         $display("FAIL fill_timeout: no done within %0d cycles", budget);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (fifo_write !== 1'b0) begin bad++; $display("FAIL reset_write: got %b expected 0", fifo_write); end
      total++; if (fifo_data !== '0) begin bad++; $display("FAIL reset_data: got %h expected 0", fifo_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
      total++; if (pixel_count !== '0) begin bad++; $display("FAIL reset_count: got %0d expected 0", pixel_count); end
      @(posedge clk); #1;
      resetn = 1'b1;
   endtask

   task automatic test_solid();
      int dc;
      start_fill(1'b0, 4, 2, 32'hFF00FF00, $urandom);
      run_and_wait(40, 0, -1, 1'b0, 0, dc);
      total++; if (dc !== 9) begin bad++; $display("FAIL solid_done_cycle: got %0d expected 9", dc); end
      total++; if (pixel_count !== 8) begin bad++; $display("FAIL solid_count: got %0d expected 8", pixel_count); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL solid_busy_in_done: got %b expected 1", busy); end
      total++; if (wr_idx !== 8) begin bad++; $display("FAIL solid_writes: got %0d expected 8", wr_idx); end
      @(posedge clk); #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL solid_idle_after: busy %b expected 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL solid_done_width: done %b expected 0", done); end
   endtask

   task automatic test_checker();
      int dc;
      start_fill(1'b1, 16, 16, 32'h0, 32'h1);
      run_and_wait(400, 0, -1, 1'b0, 0, dc);
      total++; if (dc !== 257) begin bad++; $display("FAIL checker_done_cycle: got %0d expected 257", dc); end
      total++; if (pixel_count !== 256) begin bad++; $display("FAIL checker_count: got %0d expected 256", pixel_count); end
      total++; if (cap[8] !== 32'h1) begin bad++; $display("FAIL checker_px_8_0: got %h expected 1", cap[8]); end
      total++; if (cap[136] !== 32'h0) begin bad++; $display("FAIL checker_px_8_8: got %h expected 0", cap[136]); end
      total++; if (cap[128] !== 32'h1) begin bad++; $display("FAIL checker_px_0_8: got %h expected 1", cap[128]); end
      total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL checker_left: %0d pixels not written, expected 0", exp_q.size()); end
   endtask

   task automatic test_full_stall();
      int dc;
      start_fill(1'b0, 4, 1, $urandom, $urandom);
      run_and_wait(40, 2, 5, 1'b0, 0, dc);
      total++; if (dc !== 9) begin bad++; $display("FAIL stall_done_cycle: got %0d expected 9", dc); end
      total++; if (wr_idx !== 4) begin bad++; $display("FAIL stall_writes: got %0d expected 4", wr_idx); end
      total++; if (pixel_count !== 4) begin bad++; $display("FAIL stall_count: got %0d expected 4", pixel_count); end
   endtask

   task automatic test_zero_size();
      int dc;
      start_fill(1'b0, 0, 5, $urandom, $urandom);
      run_and_wait(10, 0, -1, 1'b0, 0, dc);
      total++; if (dc !== 1) begin bad++; $display("FAIL zero_done_cycle: got %0d expected 1", dc); end
      total++; if (wr_idx !== 0) begin bad++; $display("FAIL zero_writes: got %0d expected 0", wr_idx); end
      total++; if (pixel_count !== 0) begin bad++; $display("FAIL zero_count: got %0d expected 0", pixel_count); end
   endtask

   task automatic test_abort();
      int dc;
      start_fill(1'b1, 8, 8, $urandom, $urandom);
      for (int c = 1; c <= 10; c++) begin
         if (c > 1) begin @(posedge clk); #1; end
         @(negedge clk);
      end
      @(posedge clk); #1;
      abort = 1'b1;
      @(negedge clk);
      total++; if (fifo_write !== 1'b0) begin bad++; $display("FAIL abort_no_write: got %b expected 0", fifo_write); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_no_done: got %b expected 0", done); end
      @(posedge clk); #1;
      abort = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle: busy %b expected 0", busy); end
      total++; if (pixel_count !== 10) begin bad++; $display("FAIL abort_count: got %0d expected 10", pixel_count); end
      total++; if (wr_idx !== 10) begin bad++; $display("FAIL abort_writes: got %0d expected 10", wr_idx); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_late_done: got %b expected 0", done); end
      exp_q.delete();
      start_fill(1'b0, 8, 8, $urandom, $urandom);
      run_and_wait(100, 0, -1, 1'b0, 0, dc);
      total++; if (dc !== 65) begin bad++; $display("FAIL refill_done_cycle: got %0d expected 65", dc); end
      total++; if (pixel_count !== 64) begin bad++; $display("FAIL refill_count: got %0d expected 64", pixel_count); end
   endtask

   // Random sizes and back-pressure, with a stray start pulse while busy.
   task automatic test_random();
      int dc, w, h;
      for (int i = 0; i < 4; i++) begin
         w = $urandom_range(1, 10);
         h = $urandom_range(1, 10);
         start_fill(1'($urandom_range(0, 1)), w, h, $urandom, $urandom);
         run_and_wait(600, 0, -1, 1'b1, 3, dc);
         total++; if (pixel_count !== (w * h)) begin bad++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, pixel_count, w * h); end
         total++; if (wr_idx !== (w * h)) begin bad++; $display("FAIL rand_writes[%0d]: got %0d expected %0d", i, wr_idx, w * h); end
         @(posedge clk); #1;
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand_idle[%0d]: busy %b expected 0", i, busy); end
      end
   endtask

   task automatic test_reset_mid_fill();
      int dc;
      start_fill(1'b1, 8, 8, $urandom, $urandom);
      repeat (5) @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      total++; if (fifo_write !== 1'b0) begin bad++; $display("FAIL midrst_write: got %b expected 0", fifo_write); end
      total++; if (fifo_data !== '0) begin bad++; $display("FAIL midrst_data: got %h expected 0", fifo_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b expected 0", done); end
      total++; if (pixel_count !== '0) begin bad++; $display("FAIL midrst_count: got %0d expected 0", pixel_count); end
      exp_q.delete();
      @(posedge clk); #1;
      resetn = 1'b1;
      start_fill(1'b0, 3, 2, $urandom, $urandom);
      run_and_wait(40, 0, -1, 1'b0, 0, dc);
      total++; if (dc !== 7) begin bad++; $display("FAIL postrst_done_cycle: got %0d expected 7", dc); end
      total++; if (pixel_count !== 6) begin bad++; $display("FAIL postrst_count: got %0d expected 6", pixel_count); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      resetn = 1'b0;
      start  = 1'b0;
      abort  = 1'b0;
      mode   = 1'b0;
      width  = '0;
      height = '0;
      color0 = '0;
      color1 = '0;
      full   = 1'b0;
      last_data = '0;
      test_reset();
      test_solid();
      test_checker();
      test_full_stall();
      test_zero_size();
      test_abort();
      test_random();
      test_reset_mid_fill();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_painterengine_gpu_fill_writer
